// File: rtl/bsg_manycore_pkg.sv
// rtl/bsg_manycore_pkg.sv - shared types for the manycore store tracker
package bsg_manycore_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } bsg_store_fence_state_e;

  // CSR address the core loads from to read the outstanding-store counter
  localparam logic [11:0] store_tracker_csr_addr_gp = 12'h0c0;

endpackage

// File: rtl/bsg_sat_updown_counter.sv
// rtl/bsg_sat_updown_counter.sv - saturating up/down counter with sticky underflow flag
module bsg_sat_updown_counter #(
  parameter int width_p = 16,
  parameter int max_p   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inc,
  input  logic               dec,
  output logic [width_p-1:0] count,
  output logic               underflow
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_p);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      underflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count != max_lp) count <= count + width_p'(1);
    end else if (dec && !inc) begin
      // a decrement at zero holds the count and latches the error
      if (count != '0) count <= count - width_p'(1);
      else             underflow <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk or negedge reset_n) begin
    if (reset_n) begin
      if (dec && !inc && count == '0)
        $display("%m: store acknowledge arrived with no outstanding stores (underflow)");
      assert (!(inc && count == '1))
        else $error("%m: increment at full-scale count");
    end
  end
`endif

endmodule

// File: rtl/bsg_manycore_store_tracker.sv
// rtl/bsg_manycore_store_tracker.sv - outstanding remote-store tracker with credit, fence and readout
module bsg_manycore_store_tracker
  import bsg_manycore_pkg::*;
#(
  parameter int cntr_width_p    = 16,
  parameter int max_out_p       = 64,
  parameter int data_width_p    = 32,
  parameter int fence_timeout_p = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    st_v_i,
  input  logic                    st_local_i,
  input  logic                    st_ready_i,
  output logic                    st_credit_o,
  input  logic                    ret_v_i,
  input  logic                    ret_local_i,
  output logic                    ret_ready_o,
  input  logic                    fence_v_i,
  output logic                    fence_yumi_o,
  output logic                    fence_timeout_o,
  input  logic                    rd_v_i,
  output logic                    rd_v_o,
  output logic [data_width_p-1:0] rd_data_o,
  output logic [cntr_width_p-1:0] count_o,
  output logic                    underflow_o
);

  localparam int tmo_width_lp = $clog2(fence_timeout_p + 2);

  bsg_store_fence_state_e  state_r, state_n;
  logic [tmo_width_lp-1:0] drain_cyc_r, drain_cyc_n;
  logic draining, below_max, inc, dec, zero_next, timeout_hit;

  assign draining    = (state_r == DRAIN);
  assign dec         = ret_v_i & ~ret_local_i;
  assign below_max   = (count_o < cntr_width_p'(max_out_p));
  // a same-cycle return frees a slot; tracked launches are blocked while draining
  assign st_credit_o = st_local_i | (~draining & (below_max | dec));
  assign inc         = st_v_i & st_credit_o & st_ready_i & ~st_local_i;
  assign ret_ready_o  = 1'b1;
  assign fence_yumi_o = (state_r == DONE);

  assign zero_next   = ~inc & ((count_o == '0) | ((count_o == cntr_width_p'(1)) & dec));
  assign drain_cyc_n = drain_cyc_r + tmo_width_lp'(1);
  assign timeout_hit = (fence_timeout_p != 0) && draining
                       && (drain_cyc_n == tmo_width_lp'(fence_timeout_p));

  bsg_sat_updown_counter #(
    .width_p (cntr_width_p),
    .max_p   (max_out_p)
  ) u_counter (
    .clk       (clk_i),
    .reset_n   (reset_n_i),
    .inc       (inc),
    .dec       (dec),
    .count     (count_o),
    .underflow (underflow_o)
  );

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (fence_v_i) state_n = (count_o == '0 && !inc) ? DONE : DRAIN;
      DRAIN:   if (zero_next || timeout_hit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r         <= IDLE;
      drain_cyc_r     <= '0;
      fence_timeout_o <= 1'b0;
      rd_v_o          <= 1'b0;
      rd_data_o       <= '0;
    end else begin
      state_r     <= state_n;
      drain_cyc_r <= draining ? drain_cyc_n : '0;
      // a fence that drains on the deadline cycle is not a timeout
      if (timeout_hit && !zero_next) fence_timeout_o <= 1'b1;
      rd_v_o <= rd_v_i;
      if (rd_v_i) rd_data_o <= data_width_p'(count_o);
    end
  end

endmodule

// File: tb/tb_bsg_manycore_store_tracker.sv
// tb/tb_bsg_manycore_store_tracker.sv - directed bench for the store tracker
`timescale 1ns/1ps
module tb_bsg_manycore_store_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic st_v = 1'b0, st_local = 1'b0, st_ready = 1'b0;
  logic ret_v = 1'b0, ret_local = 1'b0, fence_v = 1'b0, rd_v = 1'b0;

  logic        big_credit, big_ret_ready, big_yumi, big_tmo, big_rd_v, big_uf;
  logic [31:0] big_rd_data;
  logic [15:0] big_count;
  logic        lim_credit, lim_ret_ready, lim_yumi, lim_tmo, lim_rd_v, lim_uf;
  logic [31:0] lim_rd_data;
  logic [15:0] lim_count;

  int checks = 0;
  int failures = 0;

  bsg_manycore_store_tracker #(.max_out_p(64)) u_big (
    .clk_i(clk), .reset_n_i(reset_n),
    .st_v_i(st_v), .st_local_i(st_local), .st_ready_i(st_ready), .st_credit_o(big_credit),
    .ret_v_i(ret_v), .ret_local_i(ret_local), .ret_ready_o(big_ret_ready),
    .fence_v_i(fence_v), .fence_yumi_o(big_yumi), .fence_timeout_o(big_tmo),
    .rd_v_i(rd_v), .rd_v_o(big_rd_v), .rd_data_o(big_rd_data),
    .count_o(big_count), .underflow_o(big_uf)
  );

  bsg_manycore_store_tracker #(.max_out_p(4), .fence_timeout_p(10)) u_lim (
    .clk_i(clk), .reset_n_i(reset_n),
    .st_v_i(st_v), .st_local_i(st_local), .st_ready_i(st_ready), .st_credit_o(lim_credit),
    .ret_v_i(ret_v), .ret_local_i(ret_local), .ret_ready_o(lim_ret_ready),
    .fence_v_i(fence_v), .fence_yumi_o(lim_yumi), .fence_timeout_o(lim_tmo),
    .rd_v_i(rd_v), .rd_v_o(lim_rd_v), .rd_data_o(lim_rd_data),
    .count_o(lim_count), .underflow_o(lim_uf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    st_v = 0; st_local = 0; st_ready = 0;
    ret_v = 0; ret_local = 0; fence_v = 0; rd_v = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  // n tracked stores committed on consecutive edges
  task automatic push_stores(input int n);
    st_v = 1; st_ready = 1; st_local = 0;
    repeat (n) @(posedge clk);
    #1 st_v = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_count", big_count, 0);
    check_eq("rst_credit", big_credit, 1);
    check_eq("rst_rd_v", big_rd_v, 0);
    check_eq("rst_rd_data", big_rd_data, 0);
    check_eq("rst_underflow", big_uf, 0);
    check_eq("rst_timeout", big_tmo, 0);
    check_eq("rst_yumi", big_yumi, 0);
    check_eq("rst_ret_ready", big_ret_ready, 1);

    // 1: five stores then a counter read
    push_stores(5);
    @(negedge clk);
    check_eq("t1_count", big_count, 5);
    check_eq("t1_lim_count", lim_count, 4);
    check_eq("t1_lim_credit", lim_credit, 0);
    check_eq("t1_big_credit", big_credit, 1);
    rd_v = 1;
    @(posedge clk); #1 rd_v = 0;
    @(negedge clk);
    check_eq("t1_rd_v", big_rd_v, 1);
    check_eq("t1_rd_data", big_rd_data, 5);
    check_eq("t1_lim_rd_data", lim_rd_data, 4);
    @(negedge clk);
    check_eq("t1_rd_v_low", big_rd_v, 0);
    check_eq("t1_rd_data_hold", big_rd_data, 5);

    // 2: credit limit and same-cycle return
    do_reset();
    push_stores(4);
    st_v = 1; st_ready = 1;
    @(negedge clk);
    check_eq("t2_count_full", lim_count, 4);
    check_eq("t2_credit_full", lim_credit, 0);
    ret_v = 1;
    #1 check_eq("t2_credit_ret", lim_credit, 1);
    @(posedge clk); #1 ret_v = 0; st_v = 0;
    @(negedge clk);
    check_eq("t2_count_hold", lim_count, 4);
    check_eq("t2_big_count_hold", big_count, 4);
    check_eq("t2_credit_again", lim_credit, 0);

    // 3: fence with count 3, returns on cycles +2, +5, +6
    do_reset();
    push_stores(3);
    fence_v = 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      st_v = (k <= 6); st_ready = 1;
      st_local = (k == 3);
      ret_v = (k == 2 || k == 5 || k == 6);
      if (k == 8) fence_v = 0;
      @(negedge clk);
      if (k == 1) begin
        check_eq("t3_credit_drain", big_credit, 0);
        check_eq("t3_lim_credit_drain", lim_credit, 0);
      end
      if (k == 3) check_eq("t3_credit_local", big_credit, 1);
      check_eq($sformatf("t3_count_k%0d", k), big_count,
               (k <= 2) ? 3 : (k <= 5) ? 2 : (k == 6) ? 1 : 0);
      check_eq($sformatf("t3_yumi_k%0d", k), big_yumi, (k == 7));
      check_eq($sformatf("t3_lim_yumi_k%0d", k), lim_yumi, (k == 7));
    end
    clear_inputs();

    // 4: fence at zero, local stores and returns ignored
    do_reset();
    fence_v = 1;
    @(posedge clk); #1 fence_v = 0;
    @(negedge clk);
    check_eq("t4_yumi", big_yumi, 1);
    @(posedge clk); #1 st_v = 1; st_local = 1; st_ready = 1;
    @(negedge clk);
    check_eq("t4_yumi_low", big_yumi, 0);
    check_eq("t4_credit_local", lim_credit, 1);
    @(posedge clk); #1 st_v = 0; st_local = 0; ret_v = 1; ret_local = 1;
    @(negedge clk);
    check_eq("t4_count_local_st", big_count, 0);
    @(posedge clk); #1 ret_v = 0; ret_local = 0;
    @(negedge clk);
    check_eq("t4_count_local_ret", big_count, 0);
    check_eq("t4_no_underflow", big_uf, 0);

    // 5: underflow is sticky, async reset clears everything mid-cycle
    do_reset();
    ret_v = 1;
    @(posedge clk); #1 ret_v = 0;
    @(negedge clk);
    check_eq("t5_underflow", big_uf, 1);
    check_eq("t5_count_zero", big_count, 0);
    push_stores(2);
    rd_v = 1;
    @(posedge clk); #1 rd_v = 0;
    @(negedge clk);
    check_eq("t5_underflow_sticky", big_uf, 1);
    check_eq("t5_count", big_count, 2);
    check_eq("t5_rd_v", big_rd_v, 1);
    check_eq("t5_rd_data", big_rd_data, 2);
    #1 reset_n = 0;
    #1;
    check_eq("t5_arst_count", big_count, 0);
    check_eq("t5_arst_underflow", big_uf, 0);
    check_eq("t5_arst_rd_v", big_rd_v, 0);
    check_eq("t5_arst_rd_data", big_rd_data, 0);
    check_eq("t5_arst_credit", big_credit, 1);

    // 6: fence timeout after 10 drain cycles with count 2
    do_reset();
    push_stores(2);
    fence_v = 1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 12) fence_v = 0;
      @(negedge clk);
      check_eq($sformatf("t6_yumi_k%0d", k), lim_yumi, (k == 11));
      check_eq($sformatf("t6_tmo_k%0d", k), lim_tmo, (k >= 11));
    end
    check_eq("t6_count", lim_count, 2);
    check_eq("t6_big_tmo", big_tmo, 0);
    check_eq("t6_big_yumi", big_yumi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
